// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM state type and access-size decode for
// the load/store unit.
package lsu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Unlisted funct3 encodings fall through to a full-word access.
  function automatic size_t size_decode(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_decode = SZ_B;
      F3_H, F3_HU: size_decode = SZ_H;
      default:     size_decode = SZ_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] f3);
    is_unsigned = (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and DATA_MEMORY signals of the
// load/store unit. slave = the unit, master = requester plus memory side.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic                  i_valid;
  logic                  o_ready;
  logic                  i_is_store;
  logic [2:0]            i_funct3;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_done;
  logic                  o_misaligned;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wd;
  logic                  o_mem_wen;
  logic                  o_mem_ren;
  logic [DATA_WIDTH-1:0] i_mem_rd;

  modport slave (
    input  i_valid, i_is_store, i_funct3, i_addr, i_wdata, i_mem_rd,
    output o_ready, o_rdata, o_done, o_misaligned,
    output o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

  modport master (
    output i_valid, i_is_store, i_funct3, i_addr, i_wdata, i_mem_rd,
    input  o_ready, o_rdata, o_done, o_misaligned,
    input  o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic. Extracts and extends a byte/half/word
// from a memory word, and builds the write word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  size_t      sz;
  logic [7:0] word_bytes [4];

  assign sz = size_decode(funct3);

  // Per-lane byte view of the read word and per-lane write-word select.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic sel_b;
    logic sel_h;
    assign word_bytes[gi] = rd_word[8*gi +: 8];
    assign sel_b = (sz == SZ_B) && (lane == 2'(gi));
    assign sel_h = (sz == SZ_H) && (lane[1] == 1'(gi / 2));
    assign merged[8*gi +: 8] = (sz == SZ_W) ? wdata[8*gi +: 8] :
                               sel_b        ? wdata[7:0] :
                               sel_h        ? wdata[8*(gi % 2) +: 8] :
                                              rd_word[8*gi +: 8];
  end

  // Select the addressed lane and sign/zero extend it.
  always_comb begin
    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    b_sel    = word_bytes[lane];
    h_sel    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ext_data = rd_word;
    case (sz)
      SZ_B: ext_data = is_unsigned(funct3) ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
      SZ_H: ext_data = is_unsigned(funct3) ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
      default: ext_data = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-only DATA_MEMORY
// with registered read. Sub-word stores use read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned H/W accesses
// instead of force-aligning them).
module load_store_unit
  import lsu_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst,
  load_store_unit_if.slave bus
);

  state_t      state_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wd_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic        is_store_reg;
  logic        done_reg;

  size_t       req_size;
  logic [1:0]  req_lane;
  logic        accept_ok;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign req_size = size_decode(bus.i_funct3);

  // Force-aligned lane; identical to the raw bits for aligned requests.
  always_comb begin
    req_lane = bus.i_addr[1:0];
    case (req_size)
      SZ_H:    req_lane = {bus.i_addr[1], 1'b0};
      SZ_W:    req_lane = 2'b00;
      default: req_lane = bus.i_addr[1:0];
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_reg;
  logic mis_req;
  assign mis_req = ((req_size == SZ_H) && bus.i_addr[0]) ||
                   ((req_size == SZ_W) && (bus.i_addr[1:0] != 2'b00));
  assign accept_ok = !mis_req;
  assign bus.o_misaligned = mis_reg;
`else
  assign accept_ok = 1'b1;
  assign bus.o_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .rd_word  (bus.i_mem_rd),
    .wdata    (wdata_reg),
    .lane     (lane_reg),
    .funct3   (funct3_reg),
    .ext_data (ext_data),
    .merged   (merged)
  );

  // Control FSM with all request, result and memory-side registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      mem_addr_reg <= '0;
      mem_wd_reg   <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      funct3_reg   <= F3_W;
      lane_reg     <= 2'b00;
      is_store_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_reg  <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_valid) begin
            mem_addr_reg <= {bus.i_addr[31:2], 2'b00};
            if (accept_ok) begin
              lane_reg     <= req_lane;
              funct3_reg   <= bus.i_funct3;
              wdata_reg    <= bus.i_wdata;
              is_store_reg <= bus.i_is_store;
              if (bus.i_is_store && (req_size == SZ_W)) begin
                mem_wd_reg <= bus.i_wdata;
                state_reg  <= ST_WRITE;
              end else begin
                state_reg  <= ST_READ;
              end
            end
`ifdef MISALIGN_TRAP_EN
            else begin
              done_reg  <= 1'b1;
              mis_reg   <= 1'b1;
              rdata_reg <= '0;
            end
`endif
          end
        end
        ST_READ: state_reg <= ST_MERGE;
        ST_MERGE: begin
          if (is_store_reg) begin
            mem_wd_reg <= merged;
            state_reg  <= ST_WRITE;
          end else begin
            rdata_reg <= ext_data;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = (state_reg == ST_IDLE);
  assign bus.o_mem_ren  = (state_reg == ST_READ);
  assign bus.o_mem_wen  = (state_reg == ST_WRITE);
  assign bus.o_mem_addr = mem_addr_reg;
  assign bus.o_mem_wd   = mem_wd_reg;
  assign bus.o_rdata    = rdata_reg;
  assign bus.o_done     = done_reg;

endmodule
